butterworth_iir_filter: RTL and testbench



---
 rtl/butterworth_iir_filter.sv | 78 +++++++
 tb/tb_butterworth_iir_filter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/butterworth_iir_filter.sv
// 2nd-order low-pass Butterworth biquad, Direct Form I, signed fixed point.
// One sample in and one filtered sample out on every rising clock edge.
module butterworth_iir_filter #(
    parameter int WIDTH  = 32,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int B0     = 4799,
    parameter int B1     = 9598,
    parameter int B2     = 4799,
    parameter int A1     = 0,
    parameter int A2     = 2811
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] xin,
    output logic signed [WIDTH-1:0] yout
);

    // Accumulator wide enough that no partial sum can overflow.
    localparam int AW = (WIDTH + COEF_W + 3 > 64) ? WIDTH + COEF_W + 3 : 64;

    // Coefficients trimmed to their declared width, then sign-extended.
    localparam logic signed [COEF_W-1:0] B0_C = COEF_W'(B0);
    localparam logic signed [COEF_W-1:0] B1_C = COEF_W'(B1);
    localparam logic signed [COEF_W-1:0] B2_C = COEF_W'(B2);
    localparam logic signed [COEF_W-1:0] A1_C = COEF_W'(A1);
    localparam logic signed [COEF_W-1:0] A2_C = COEF_W'(A2);

    localparam logic signed [AW-1:0] B0_W = AW'(B0_C);
    localparam logic signed [AW-1:0] B1_W = AW'(B1_C);
    localparam logic signed [AW-1:0] B2_W = AW'(B2_C);
    localparam logic signed [AW-1:0] A1_W = AW'(A1_C);
    localparam logic signed [AW-1:0] A2_W = AW'(A2_C);

    // Output range limits expressed at accumulator width.
    localparam logic signed [AW-1:0] Y_MAX = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN = {{(AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic signed [WIDTH-1:0] x1_q, x2_q, y1_q, y2_q;
    logic signed [WIDTH-1:0] y_d;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    acc_shift;

    // Single-cycle MAC, floor scaling and saturation to the sample range.
    always_comb begin
        acc = B0_W * AW'(xin)
            + B1_W * AW'(x1_q)
            + B2_W * AW'(x2_q)
            - A1_W * AW'(y1_q)
            - A2_W * AW'(y2_q);
        acc_shift = acc >>> FRAC;
        if (acc_shift > Y_MAX) begin
            y_d = Y_MAX[WIDTH-1:0];
        end else if (acc_shift < Y_MIN) begin
            y_d = Y_MIN[WIDTH-1:0];
        end else begin
            y_d = acc_shift[WIDTH-1:0];
        end
    end

    // Output register and delay lines; feedback keeps the saturated output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            yout <= '0;
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            yout <= y_d;
            x2_q <= x1_q;
            x1_q <= xin;
            y2_q <= y1_q;
            y1_q <= y_d;
        end
    end

endmodule

// File: tb/tb_butterworth_iir_filter.sv
// Scoreboard bench for butterworth_iir_filter with a longint reference model.
module tb_butterworth_iir_filter;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] xin;
    logic signed [31:0] yout;

    int total = 0;
    int bad   = 0;

    longint sb[$];
    // Reference history: most recent first.
    longint xh[2];
    longint yh[2];

    butterworth_iir_filter dut (
        .clk  (clk),
        .rst  (rst),
        .xin  (xin),
        .yout (yout)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        xh[0] = 0; xh[1] = 0; yh[0] = 0; yh[1] = 0;
    endfunction

    // Difference equation evaluated directly with wide integers.
    function automatic longint model_step(longint x);
        longint acc, y;
        acc = 4799 * x + 9598 * xh[0] + 4799 * xh[1] - 0 * yh[0] - 2811 * yh[1];
        y = acc >>> 14;
        if (y > MAXV) y = MAXV;
        if (y < MINV) y = MINV;
        xh[1] = xh[0]; xh[0] = x;
        yh[1] = yh[0]; yh[0] = y;
        return y;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit ok, input longint act);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d outside required bound", name, act);
        end
    endtask

    // Present one sample; the expected response is queued once it is captured.
    task automatic send(input longint x);
        xin = 32'(x);
        @(posedge clk);
        #1;
        sb.push_back(model_step(x));
    endtask

    // Asynchronous reset away from any clock edge, then release mid-cycle.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset", longint'(yout), 0);
        model_clear();
        #1;
        rst = 1'b1;
    endtask

    // Monitor: one registered output per cycle, read on the falling edge.
    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            check("stream", longint'(yout), sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint x;
        model_clear();
        xin = '0;
        rst = 1'b0;
        #1;
        check("reset_initial", longint'(yout), 0);

        // Clocks with random input while held in reset.
        for (int i = 0; i < 4; i++) begin
            xin = $urandom();
            @(posedge clk);
            #1;
            check("reset_hold", longint'(yout), 0);
        end
        @(negedge clk);
        #3;
        rst = 1'b1;

        // Zero input stays zero.
        for (int i = 0; i < 6; i++) send(0);

        // Impulse.
        send(16384);
        check("impulse0", longint'(yout), 4799);
        send(0);
        check("impulse1", longint'(yout), 9598);
        send(0);
        check("impulse2", longint'(yout), 3975);
        send(0);
        check("impulse3", longint'(yout), -1647);
        for (int i = 0; i < 8; i++) send(0);

        // Step to 1000 from rest.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            send(1000);
            if (i == 0) check("step0", longint'(yout), 292);
            if (i == 1) check("step1", longint'(yout), 878);
            if (i == 2) check("step2", longint'(yout), 1121);
            if (i >= 20) check_true("step_settle",
                                    (yout >= 999) && (yout <= 1001), longint'(yout));
        end

        // Nyquist-rate input is rejected.
        for (int i = 0; i < 14; i++) begin
            send((i % 2 == 0) ? 10000 : -10000);
            if (i >= 10) check_true("nyquist", (yout >= -2) && (yout <= 2), longint'(yout));
        end

        // Positive saturation.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send(MAXV);
            check_true("sat_pos", yout > 0, longint'(yout));
        end

        // Negative saturation.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send(MINV);
            check_true("sat_neg", yout < 0, longint'(yout));
        end

        // Random full-range and moderate-range samples.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            x = longint'($signed($urandom()));
            send(x);
        end
        for (int i = 0; i < 200; i++) begin
            x = longint'($urandom_range(40000, 0)) - 20000;
            send(x);
        end

        // Reset mid-stream, then restart from zero history.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            x = longint'($urandom_range(2000000, 0)) - 1000000;
            send(x);
        end

        @(negedge clk);
        #1;
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
